// File: rtl/manual_coloring_solver.sv
// Depth-first backtracking colorer for a fixed 6-vertex tree (v0-v1, v1-v2, v1-v5, v2-v3, v3-v4)
// with individually enabled edges. The solver tries one candidate color per cycle.
module manual_coloring_solver #(
    parameter int unsigned STEP_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4:0]        edge_mask,
    input  logic [1:0]        max_color,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [11:0]       coloring,
    output logic [STEP_W-1:0] steps
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TEST,
        S_POP,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [4:0]          mask_q;
    logic [1:0]          maxc_q;
    logic [2:0]          v_q;
    logic [2:0]          c_q;
    logic [11:0]         col_q;
    logic                busy_q;
    logic                done_q;
    logic                found_q;
    logic [11:0]         coloring_q;
    logic [STEP_W-1:0]   steps_q;

    logic [STEP_W-1:0]   steps_d;
    logic [11:0]         col_d;
    logic [2:0]          v_prev;
    logic [1:0]          prev_col;
    logic [2:0]          nbr_idx;
    logic                nbr_en;
    logic [1:0]          nbr_col;
    logic                conflict;
    logic                exhausted;

    // Every vertex has at most one lower-index neighbour in this tree.
    always_comb begin
        nbr_idx = 3'd0;
        nbr_en  = 1'b0;
        case (v_q)
            3'd1: begin nbr_idx = 3'd0; nbr_en = mask_q[0]; end
            3'd2: begin nbr_idx = 3'd1; nbr_en = mask_q[1]; end
            3'd3: begin nbr_idx = 3'd2; nbr_en = mask_q[3]; end
            3'd4: begin nbr_idx = 3'd3; nbr_en = mask_q[4]; end
            3'd5: begin nbr_idx = 3'd1; nbr_en = mask_q[2]; end
            default: begin nbr_idx = 3'd0; nbr_en = 1'b0; end
        endcase
    end

    always_comb begin
        nbr_col   = col_q[{nbr_idx, 1'b0} +: 2];
        conflict  = nbr_en && (c_q == {1'b0, nbr_col});
        exhausted = (c_q > {1'b0, maxc_q});
        v_prev    = v_q - 3'd1;
        prev_col  = col_q[{v_prev, 1'b0} +: 2];
        steps_d   = (&steps_q) ? steps_q : steps_q + STEP_W'(1);
        col_d     = col_q;
        col_d[{v_q, 1'b0} +: 2] = c_q[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            maxc_q     <= '0;
            v_q        <= '0;
            c_q        <= '0;
            col_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
            coloring_q <= '0;
            steps_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mask_q     <= edge_mask;
                        maxc_q     <= max_color;
                        steps_q    <= '0;
                        v_q        <= '0;
                        c_q        <= '0;
                        col_q      <= '0;
                        found_q    <= 1'b0;
                        coloring_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_TEST;
                    end
                end
                S_TEST: begin
                    steps_q <= steps_d;
                    if (exhausted) begin
                        state_q <= S_POP;
                    end else if (conflict) begin
                        c_q <= c_q + 3'd1;
                    end else begin
                        col_q <= col_d;
                        if (v_q == 3'd5) begin
                            found_q    <= 1'b1;
                            coloring_q <= col_d;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            v_q <= v_q + 3'd1;
                            c_q <= 3'd0;
                        end
                    end
                end
                S_POP: begin
                    if (v_q == 3'd0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        v_q     <= v_prev;
                        c_q     <= {1'b0, prev_col} + 3'd1;
                        state_q <= S_TEST;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign found    = found_q;
    assign coloring = coloring_q;
    assign steps    = steps_q;

endmodule

// File: tb/tb_manual_coloring_solver.sv
// Bench for manual_coloring_solver: directed and random searches compared with a reference
// built from exhaustive lexicographic enumeration plus a backtracking cost count.
module tb_manual_coloring_solver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  edge_mask = '0;
    logic [1:0]  max_color = '0;
    logic        busy, done, found;
    logic [11:0] coloring;
    logic [11:0] steps;
    logic        busy3, done3, found3;
    logic [11:0] coloring3;
    logic [2:0]  steps3;

    int checks = 0;
    int passed = 0;

    int ea[5] = '{0, 1, 1, 2, 3};
    int eb[5] = '{1, 2, 5, 3, 4};

    always #5 clk = ~clk;

    manual_coloring_solver #(.STEP_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .edge_mask(edge_mask), .max_color(max_color),
        .busy(busy), .done(done), .found(found), .coloring(coloring), .steps(steps)
    );

    manual_coloring_solver #(.STEP_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .edge_mask(edge_mask), .max_color(max_color),
        .busy(busy3), .done(done3), .found(found3), .coloring(coloring3), .steps(steps3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit valid_col(input logic [4:0] m, input logic [11:0] col);
        for (int e = 0; e < 5; e++)
            if (m[e] && col[2*ea[e] +: 2] == col[2*eb[e] +: 2]) return 1'b0;
        return 1'b1;
    endfunction

    // First valid coloring in lexicographic order (v0 most significant) equals the DFS result.
    function automatic void ref_first(input logic [4:0] m, input int mc,
                                      output bit f, output logic [11:0] col);
        int n, total, r;
        logic [11:0] cand;
        n = mc + 1;
        total = n ** 6;
        f = 1'b0;
        col = '0;
        for (int idx = 0; idx < total; idx++) begin
            cand = '0;
            r = idx;
            for (int v = 5; v >= 0; v--) begin
                cand[2*v +: 2] = 2'(r % n);
                r = r / n;
            end
            if (valid_col(m, cand)) begin
                f = 1'b1;
                col = cand;
                return;
            end
        end
    endfunction

    function automatic bit clash(input logic [4:0] m, input int v, input int c, input int col[6]);
        for (int e = 0; e < 5; e++)
            if (m[e] && eb[e] == v && col[ea[e]] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Candidate evaluations (TEST cycles) and backtracks (POP cycles) of the search.
    function automatic void ref_cost(input logic [4:0] m, input int mc,
                                     output int st, output int pops);
        int col[6];
        int v, c;
        v = 0; c = 0; st = 0; pops = 0;
        for (int i = 0; i < 6; i++) col[i] = 0;
        for (int k = 0; k < 10000; k++) begin
            st++;
            if (c > mc) begin
                pops++;
                if (v == 0) return;
                v--;
                c = col[v] + 1;
            end else if (!clash(m, v, c, col)) begin
                col[v] = c;
                if (v == 5) return;
                v++;
                c = 0;
            end else begin
                c++;
            end
        end
    endfunction

    task automatic run(input logic [4:0] m, input logic [1:0] mc, input bit disturb, input string tag,
                       output int st_o, output bit f_o, output logic [11:0] col_o);
        bit ef;
        logic [11:0] ecol;
        int est, epops, cyc, bcnt;
        ref_first(m, int'(mc), ef, ecol);
        ref_cost(m, int'(mc), est, epops);
        @(negedge clk);
        edge_mask = m;
        max_color = mc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("%s busy_after_start", tag), busy, 1);
        check($sformatf("%s found_cleared", tag), found, 0);
        check($sformatf("%s coloring_cleared", tag), coloring, 0);
        cyc = 1;
        bcnt = 0;
        while (!done && cyc < 300) begin
            if (busy) bcnt++;
            if (disturb && cyc == 2) begin
                start = 1'b1;
                edge_mask = 5'($urandom);
                max_color = 2'($urandom);
            end
            if (disturb && cyc == 3) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check($sformatf("%s done_seen", tag), done, 1);
        check($sformatf("%s done_cycle", tag), cyc, est + epops + 1);
        check($sformatf("%s busy_cycles", tag), bcnt, est + epops);
        check($sformatf("%s busy_at_done", tag), busy, 0);
        check($sformatf("%s found", tag), found, ef);
        check($sformatf("%s coloring", tag), coloring, ecol);
        check($sformatf("%s steps", tag), steps, est);
        check($sformatf("%s steps_sat", tag), steps3, (est > 7) ? 7 : est);
        if (found) check($sformatf("%s proper", tag), valid_col(m, coloring), 1);
        @(negedge clk);
        check($sformatf("%s done_pulse_end", tag), done, 0);
        check($sformatf("%s found_hold", tag), found, ef);
        check($sformatf("%s coloring_hold", tag), coloring, ecol);
        st_o = est;
        f_o = ef;
        col_o = ecol;
    endtask

    initial begin
        int st;
        bit f;
        logic [11:0] col;
        int st_a;
        logic [11:0] col_a;
        logic [4:0] rm;
        logic [1:0] rc;

        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset found", found, 0);
        check("reset coloring", coloring, 0);
        check("reset steps", steps, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run(5'h1F, 2'd3, 1'b0, "full_m3", st_a, f, col_a);
        check("full_m3 found_const", f, 1);

        run(5'h1F, 2'd0, 1'b0, "full_m0", st, f, col);
        check("full_m0 steps_const", st, 4);
        check("full_m0 found_const", found, 0);

        run(5'h00, 2'd0, 1'b0, "none_m0", st, f, col);
        check("none_m0 steps_const", steps, 6);
        check("none_m0 coloring_const", coloring, 12'h000);

        run(5'h1F, 2'd3, 1'b1, "disturbed", st, f, col);
        check("disturbed same_steps", steps, st_a);
        check("disturbed same_coloring", coloring, col_a);

        // Reset in the middle of a search.
        @(negedge clk);
        edge_mask = 5'h1F;
        max_color = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset found", found, 0);
        check("midreset coloring", coloring, 0);
        check("midreset steps", steps, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(5'h1F, 2'd3, 1'b0, "after_reset", st, f, col);
        check("after_reset same_steps", steps, st_a);
        check("after_reset same_coloring", coloring, col_a);

        for (int i = 0; i < 16; i++) begin
            rm = 5'($urandom);
            rc = 2'($urandom_range(1, 3));
            run(rm, rc, i[0], $sformatf("rand%0d", i), st, f, col);
            check($sformatf("rand%0d tree_found", i), found, 1);
        end
        for (int i = 0; i < 4; i++) begin
            rm = 5'($urandom);
            run(rm, 2'd0, 1'b0, $sformatf("rand_m0_%0d", i), st, f, col);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
